phaser_in_mlane_ctrl: RTL and testbench
=======================================

Name: phaser_in_mlane_ctrl

Overview:
Parametrised multi-lane, multi-rank fine-phase controller for the read-capture path. It generalises the single-lane phaser-in control to NUM_LANES lanes and NUM_RANKS ranks, with one tap register per rank and lane. It also generates the divided-clock enable and the ISERDES reset sequencing. It sits between the memory-PHY calibration logic and the per-lane delay/ISERDES primitives, all on SYSCLK.

Parameters:
NUM_LANES, 4, number of byte lanes (1..8)
NUM_RANKS, 4, number of ranks whose tap sets are stored (1..4)
TAP_W, 6, fine tap counter width
FINE_DELAY, 0, reset value of every tap register (0..2^TAP_W-1)
CLKOUT_DIV, 4, divided-clock ratio (2..16)
SYNC_IN_DIV_RST, 0, 1 = SYNCIN rising edge realigns the divider
EN_ISERDES_RST, 0, 1 = enable ISERDESRST sequencing
ISERDES_RST_CYCLES, 8, ISERDESRST hold length after a reset release (1..255)

Ports:
SYSCLK  in  1  single clock; all logic is on the rising edge
RST  in  1  synchronous, active-high reset
LANESEL  in  max(1,clog2(NUM_LANES))  lane targeted by adjust/load/read
RANKSEL  in  2  rank targeted by adjust/load/read; also selects the active tap set
FINEENABLE  in  1  one-cycle tap adjust strobe
FINEINC  in  1  1 = increment, 0 = decrement (sampled with FINEENABLE)
COUNTERLOADEN  in  1  load strobe
COUNTERLOADVAL  in  TAP_W  load value
COUNTERREADEN  in  1  read strobe
COUNTERREADVAL  out  TAP_W  read data
COUNTERREADVALID  out  1  read data valid pulse
FINEOVERFLOW  out  1  tap wrap pulse
DIVIDERST  in  1  divider hold reset (level)
SYNCIN  in  1  divider alignment input
TAPS  out  NUM_LANES*TAP_W  active-rank taps; lane 0 in the LSBs
ICLKDIV_EN  out  1  divided-clock enable, one pulse per CLKOUT_DIV cycles
ISERDESRST  out  1  ISERDES reset

Behaviour:
- Reset (RST=1 at a clock edge):
  - all tap registers load FINE_DELAY; active rank = 0;
  - COUNTERREADVAL=0, COUNTERREADVALID=0, FINEOVERFLOW=0, ICLKDIV_EN=0;
  - divider count=0; SYNCIN edge register=0;
  - ISERDESRST = EN_ISERDES_RST; FSM goes to HOLD.
- Out-of-range address: RANKSEL>=NUM_RANKS or LANESEL>=NUM_LANES ignores load and adjust, reads return 0, and the active rank does not change.
- Active rank: RANKSEL is registered each cycle when in range. TAPS reflects the new rank from the following cycle, i.e. 1-cycle latency.
- Tap update priority per cycle is COUNTERLOADEN, then FINEENABLE:
  - load writes COUNTERLOADVAL to tap[RANKSEL][LANESEL]; FINEOVERFLOW stays 0 for that cycle;
  - an adjust with no load does +1 or -1 modulo 2^TAP_W;
  - FINEOVERFLOW is a 1-cycle pulse, the cycle after an increment from max (wraps to 0) or a decrement from 0 (wraps to max);
  - a new write is visible on TAPS the next cycle.
- Read: COUNTERREADEN registers tap[RANKSEL][LANESEL] into COUNTERREADVAL, with COUNTERREADVALID=1, one cycle later.
  - If a read and a write hit the same tap in the same cycle, the read returns the pre-write value.
  - COUNTERREADVAL holds its value until the next read; VALID is a single-cycle pulse.
- Divider:
  - count runs 0..CLKOUT_DIV-1 and wraps;
  - ICLKDIV_EN is registered high in the cycle after count==CLKOUT_DIV-1, so one pulse every CLKOUT_DIV cycles;
  - while DIVIDERST=1, count=0 and ICLKDIV_EN=0;
  - if SYNC_IN_DIV_RST=1, a SYNCIN rising edge (SYNCIN=1 while its previous sample was 0) forces count=0 next cycle, with no pulse that cycle; SYNCIN is ignored when the parameter is 0;
  - DIVIDERST takes priority over SYNCIN.
- ISERDES reset FSM (only when EN_ISERDES_RST=1; otherwise ISERDESRST=0 permanently and the FSM stays in RUN):
  - HOLD: ISERDESRST=1. Leaves when RST=0 and DIVIDERST=0, loading cnt=ISERDES_RST_CYCLES-1, and goes to COUNT.
  - COUNT: ISERDESRST=1; cnt decrements; goes to RUN when cnt==0.
  - RUN: ISERDESRST=0.
  - DIVIDERST=1 in any state returns the FSM to HOLD next cycle; a DIVIDERST during COUNT restarts the full sequence.
  - Total ISERDESRST assertion after release is ISERDES_RST_CYCLES cycles.
- RST asserted mid-operation aborts everything, pending reads included; no VALID pulse is issued for an aborted read.

Test Plan:
1. Reset, FINE_DELAY=5, NUM_LANES=4 -> TAPS=0x145145 (four lanes of 5), ICLKDIV_EN pulses every 4th cycle starting 4 cycles after release.
2. RANKSEL=1, LANESEL=2: load 63, then FINEENABLE with FINEINC=1 -> tap=0, FINEOVERFLOW 1-cycle pulse; decrement -> 63, second pulse; rank 0 taps unchanged.
3. Same-cycle load 10, adjust and read on lane 1 (old value 20) -> COUNTERREADVAL=20 with VALID; next read returns 10; no overflow.
4. Switch RANKSEL 0->2 with distinct tap sets -> TAPS changes exactly 1 cycle later; RANKSEL=3 with NUM_RANKS=2 -> TAPS unchanged, read returns 0.
5. SYNC_IN_DIV_RST=1, SYNCIN rises at count=2 -> count=0 next cycle, next pulse 4 cycles later; SYNCIN held high gives no further realignment; DIVIDERST=1 -> ICLKDIV_EN=0.
6. EN_ISERDES_RST=1, ISERDES_RST_CYCLES=8: release RST -> ISERDESRST low after exactly 8 cycles; pulse DIVIDERST at cycle 4 of COUNT -> full 8-cycle sequence restarts after DIVIDERST drops.

Source files
------------

// File: rtl/phaser_in_mlane_ctrl.sv
// Multi-lane, multi-rank fine-phase tap controller with divided-clock enable
// and ISERDES reset sequencing; all outputs registered on SYSCLK, 1-cycle latency.
module phaser_in_mlane_ctrl #(
  parameter int NUM_LANES          = 4,
  parameter int NUM_RANKS          = 4,
  parameter int TAP_W              = 6,
  parameter int FINE_DELAY         = 0,
  parameter int CLKOUT_DIV         = 4,
  parameter int SYNC_IN_DIV_RST    = 0,
  parameter int EN_ISERDES_RST     = 0,
  parameter int ISERDES_RST_CYCLES = 8,
  localparam int LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic                       SYSCLK,
  input  logic                       RST,
  input  logic [LW-1:0]              LANESEL,
  input  logic [1:0]                 RANKSEL,
  input  logic                       FINEENABLE,
  input  logic                       FINEINC,
  input  logic                       COUNTERLOADEN,
  input  logic [TAP_W-1:0]           COUNTERLOADVAL,
  input  logic                       COUNTERREADEN,
  output logic [TAP_W-1:0]           COUNTERREADVAL,
  output logic                       COUNTERREADVALID,
  output logic                       FINEOVERFLOW,
  input  logic                       DIVIDERST,
  input  logic                       SYNCIN,
  output logic [NUM_LANES*TAP_W-1:0] TAPS,
  output logic                       ICLKDIV_EN,
  output logic                       ISERDESRST
);

  localparam int NL2 = 2 ** LW;
  localparam logic [1:0] ST_HOLD  = 2'd0;
  localparam logic [1:0] ST_COUNT = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;

  // Arrays span the full address space so RANKSEL/LANESEL index them directly;
  // entries beyond NUM_RANKS/NUM_LANES are never written.
  logic [TAP_W-1:0] tap_q [4][NL2];
  logic [1:0]       rank_q;
  logic [3:0]       div_cnt;
  logic             sync_q;
  logic [1:0]       state;
  logic [7:0]       rst_cnt;
  logic             addr_ok;
  logic [TAP_W-1:0] cur_tap;
  logic             wrap;

  assign addr_ok = (32'(RANKSEL) < NUM_RANKS) && (32'(LANESEL) < NUM_LANES);
  assign cur_tap = tap_q[RANKSEL][LANESEL];
  assign wrap    = FINEINC ? (cur_tap == {TAP_W{1'b1}}) : (cur_tap == '0);

  always_ff @(posedge SYSCLK) begin
    if (RST) begin
      for (int r = 0; r < 4; r++)
        for (int l = 0; l < NL2; l++)
          tap_q[r][l] <= TAP_W'(FINE_DELAY);
      rank_q           <= '0;
      FINEOVERFLOW     <= 1'b0;
      COUNTERREADVAL   <= '0;
      COUNTERREADVALID <= 1'b0;
    end else begin
      FINEOVERFLOW     <= addr_ok && !COUNTERLOADEN && FINEENABLE && wrap;
      COUNTERREADVALID <= COUNTERREADEN;
      if (COUNTERREADEN)
        COUNTERREADVAL <= addr_ok ? cur_tap : '0;
      if (addr_ok) begin
        rank_q <= RANKSEL;
        if (COUNTERLOADEN)
          tap_q[RANKSEL][LANESEL] <= COUNTERLOADVAL;
        else if (FINEENABLE)
          tap_q[RANKSEL][LANESEL] <= FINEINC ? cur_tap + TAP_W'(1) : cur_tap - TAP_W'(1);
      end
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_taps
    assign TAPS[g*TAP_W +: TAP_W] = tap_q[rank_q][g];
  end

  always_ff @(posedge SYSCLK) begin
    if (RST) begin
      div_cnt    <= '0;
      ICLKDIV_EN <= 1'b0;
      sync_q     <= 1'b0;
    end else begin
      sync_q <= SYNCIN;
      if (DIVIDERST || ((SYNC_IN_DIV_RST != 0) && SYNCIN && !sync_q)) begin
        div_cnt    <= '0;
        ICLKDIV_EN <= 1'b0;
      end else begin
        ICLKDIV_EN <= (32'(div_cnt) == CLKOUT_DIV - 1);
        div_cnt    <= (32'(div_cnt) == CLKOUT_DIV - 1) ? '0 : div_cnt + 4'd1;
      end
    end
  end

  always_ff @(posedge SYSCLK) begin
    if (RST) begin
      state   <= (EN_ISERDES_RST != 0) ? ST_HOLD : ST_RUN;
      rst_cnt <= '0;
    end else if (EN_ISERDES_RST == 0) begin
      state <= ST_RUN;
    end else if (DIVIDERST) begin
      state <= ST_HOLD;
    end else begin
      case (state)
        ST_HOLD: begin
          rst_cnt <= 8'(ISERDES_RST_CYCLES - 1);
          state   <= ST_COUNT;
        end
        ST_COUNT: begin
          if (rst_cnt == '0) state <= ST_RUN;
          else               rst_cnt <= rst_cnt - 8'd1;
        end
        default: state <= ST_RUN;
      endcase
    end
  end

  assign ISERDESRST = (EN_ISERDES_RST != 0) && (state != ST_RUN);

endmodule

// File: tb/tb_phaser_in_mlane_ctrl.sv
// Directed bench: DUT a (4 ranks, FINE_DELAY=5, SYNCIN realign, ISERDES seq)
// and DUT b (2 ranks, defaults) share all inputs.
module tb_phaser_in_mlane_ctrl;
  logic        clk = 1'b0;
  logic        rst, fine_en, fine_inc, load_en, read_en, div_rst, sync_in;
  logic [1:0]  lane_sel, rank_sel;
  logic [5:0]  load_val;
  logic [5:0]  a_rdval, b_rdval;
  logic        a_rdvld, b_rdvld, a_ovf, b_ovf, a_iclk, b_iclk, a_isr, b_isr;
  logic [23:0] a_taps, b_taps;
  int          passed = 0;
  int          total  = 0;

  always #5 clk = ~clk;

  phaser_in_mlane_ctrl #(.NUM_LANES(4), .NUM_RANKS(4), .TAP_W(6), .FINE_DELAY(5),
    .CLKOUT_DIV(4), .SYNC_IN_DIV_RST(1), .EN_ISERDES_RST(1), .ISERDES_RST_CYCLES(8)) dut_a (
    .SYSCLK(clk), .RST(rst), .LANESEL(lane_sel), .RANKSEL(rank_sel),
    .FINEENABLE(fine_en), .FINEINC(fine_inc), .COUNTERLOADEN(load_en),
    .COUNTERLOADVAL(load_val), .COUNTERREADEN(read_en), .COUNTERREADVAL(a_rdval),
    .COUNTERREADVALID(a_rdvld), .FINEOVERFLOW(a_ovf), .DIVIDERST(div_rst),
    .SYNCIN(sync_in), .TAPS(a_taps), .ICLKDIV_EN(a_iclk), .ISERDESRST(a_isr));

  phaser_in_mlane_ctrl #(.NUM_LANES(4), .NUM_RANKS(2)) dut_b (
    .SYSCLK(clk), .RST(rst), .LANESEL(lane_sel), .RANKSEL(rank_sel),
    .FINEENABLE(fine_en), .FINEINC(fine_inc), .COUNTERLOADEN(load_en),
    .COUNTERLOADVAL(load_val), .COUNTERREADEN(read_en), .COUNTERREADVAL(b_rdval),
    .COUNTERREADVALID(b_rdvld), .FINEOVERFLOW(b_ovf), .DIVIDERST(div_rst),
    .SYNCIN(sync_in), .TAPS(b_taps), .ICLKDIV_EN(b_iclk), .ISERDESRST(b_isr));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    rst = 1; fine_en = 0; fine_inc = 0; load_en = 0; read_en = 0;
    div_rst = 0; sync_in = 0; lane_sel = 0; rank_sel = 0; load_val = 0;
    tick(); tick();
    chk("rst_taps_a", 32'(a_taps), 32'h145145);
    chk("rst_taps_b", 32'(b_taps), 32'h0);
    chk("rst_rdval", 32'(a_rdval), 32'h0);
    chk("rst_rdvld", 32'(a_rdvld), 32'h0);
    chk("rst_ovf", 32'(a_ovf), 32'h0);
    chk("rst_iclk", 32'(a_iclk), 32'h0);
    chk("rst_isr_a", 32'(a_isr), 32'h1);
    chk("rst_isr_b", 32'(b_isr), 32'h0);

    // release: divider pulse every 4th edge, ISERDESRST high for 8 edges
    rst = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      chk("rel_iclk", 32'(a_iclk), 32'((i % 4) == 0));
      chk("rel_isr", 32'(a_isr), 32'(i <= 8));
    end

    // rank 1 lane 2: load 63, wrap up, wrap down
    rank_sel = 1; lane_sel = 2; load_en = 1; load_val = 6'd63;
    tick(); load_en = 0;
    chk("ld63_taps", 32'(a_taps), 32'h17F145);
    chk("ld63_ovf", 32'(a_ovf), 32'h0);
    fine_en = 1; fine_inc = 1;
    tick(); fine_en = 0;
    chk("inc_taps", 32'(a_taps), 32'h140145);
    chk("inc_ovf", 32'(a_ovf), 32'h1);
    tick();
    chk("inc_ovf_end", 32'(a_ovf), 32'h0);
    fine_en = 1; fine_inc = 0;
    tick(); fine_en = 0;
    chk("dec_taps", 32'(a_taps), 32'h17F145);
    chk("dec_ovf", 32'(a_ovf), 32'h1);
    rank_sel = 0;
    tick();
    chk("dec_ovf_end", 32'(a_ovf), 32'h0);
    chk("rank0_keep", 32'(a_taps), 32'h145145);

    // rank 0 lane 1: load 20, then load 10 + adjust + read together
    lane_sel = 1; load_en = 1; load_val = 6'd20;
    tick();
    load_val = 6'd10; fine_en = 1; fine_inc = 1; read_en = 1;
    tick(); load_en = 0; fine_en = 0;
    chk("rw_rdval", 32'(a_rdval), 32'd20);
    chk("rw_rdvld", 32'(a_rdvld), 32'h1);
    chk("rw_ovf", 32'(a_ovf), 32'h0);
    chk("rw_taps", 32'(a_taps), 32'h145285);
    tick(); read_en = 0;
    chk("rd2_rdval", 32'(a_rdval), 32'd10);
    chk("rd2_rdvld", 32'(a_rdvld), 32'h1);
    tick();
    chk("rd_hold_val", 32'(a_rdval), 32'd10);
    chk("rd_vld_pulse", 32'(a_rdvld), 32'h0);

    // rank 2 taps: lane0=1, lane3=9; then rank switch latency
    rank_sel = 2; lane_sel = 0; load_en = 1; load_val = 6'd1;
    tick();
    lane_sel = 3; load_val = 6'd9;
    tick(); load_en = 0;
    rank_sel = 0;
    tick();
    chk("sw_rank0", 32'(a_taps), 32'h145285);
    chk("sw_b_rank0", 32'(b_taps), 32'h280);
    rank_sel = 2;
    #1;
    chk("sw_pre_edge", 32'(a_taps), 32'h145285);
    tick();
    chk("sw_rank2", 32'(a_taps), 32'h245141);

    // rank 3: valid on a, out of range on b
    rank_sel = 3; lane_sel = 1; load_en = 1; load_val = 6'd33; read_en = 1;
    tick(); load_en = 0; read_en = 0;
    chk("oor_b_taps", 32'(b_taps), 32'h280);
    chk("oor_b_rdval", 32'(b_rdval), 32'h0);
    chk("oor_b_rdvld", 32'(b_rdvld), 32'h1);
    chk("r3_a_rdval", 32'(a_rdval), 32'd5);
    chk("r3_a_taps", 32'(a_taps), 32'h145845);
    rank_sel = 0;
    tick();
    chk("back_rank0", 32'(a_taps), 32'h145285);

    // divider: hold, SYNCIN realign at count 2 (a only), DIVIDERST
    div_rst = 1;
    tick();
    chk("drst_iclk_a", 32'(a_iclk), 32'h0);
    chk("drst_iclk_b", 32'(b_iclk), 32'h0);
    chk("drst_isr", 32'(a_isr), 32'h1);
    div_rst = 0;
    tick(); tick();
    sync_in = 1;
    tick();
    chk("sync_iclk_a", 32'(a_iclk), 32'h0);
    chk("sync_iclk_b", 32'(b_iclk), 32'h0);
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk("sync_a", 32'(a_iclk), 32'((i % 4) == 0));
      chk("sync_b", 32'(b_iclk), 32'((i % 4) == 1));
    end
    sync_in = 0; div_rst = 1;
    tick();
    chk("drst2_iclk", 32'(a_iclk), 32'h0);

    // ISERDES sequence restart by DIVIDERST at COUNT cycle 4
    tick();
    div_rst = 0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("seq1_isr", 32'(a_isr), 32'h1);
    end
    div_rst = 1;
    tick();
    chk("seq_abort_isr", 32'(a_isr), 32'h1);
    div_rst = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      chk("seq2_isr", 32'(a_isr), 32'(i <= 8));
    end

    // reset aborts a read issued in the same cycle
    read_en = 1; rst = 1;
    tick(); read_en = 0;
    chk("abort_rdvld", 32'(a_rdvld), 32'h0);
    chk("abort_rdval", 32'(a_rdval), 32'h0);
    chk("abort_taps", 32'(a_taps), 32'h145145);
    chk("abort_isr", 32'(a_isr), 32'h1);
    chk("abort_iclk", 32'(a_iclk), 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
